beat_sequencer: RTL and testbench

//  Upstream timing stage for the tone-table/LED stage. Produces the beat index

---
 rtl/beat_sequencer.sv | 132 +++++++++++++
 tb/tb_beat_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/beat_sequencer.sv
// rtl/beat_sequencer.sv - play/pause/stop transport and tempo prescaler producing the beat index for the tone stage
module beat_sequencer #(
    parameter logic [31:0] BEAT_DIV = 32'd12_500_000,
    parameter logic [11:0] LEN      = 12'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play_pls,
    input  logic        stop_pls,
    input  logic        loop_en,
    input  logic [1:0]  tempo_sel,
    output logic [11:0] ibeatNum,
    output logic        en,
    output logic        beat_tick,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [11:0] beat_q, beat_d;
    logic        en_q, en_d;
    logic        tick_q, tick_d;
    logic        done_q, done_d;
    logic [31:0] presc_q, presc_d;
    logic [31:0] period_q, period_d;
    logic [31:0] period_sel;
    logic        at_term;
    logic        finishing;

    // Highest tempos on a tiny BEAT_DIV would shift to zero; clamp so a beat is at least one clock.
    always_comb begin
        period_sel = BEAT_DIV >> tempo_sel;
        if (period_sel == 32'd0) begin
            period_sel = 32'd1;
        end
    end

    assign at_term   = (presc_q == period_q - 32'd1);
    assign finishing = at_term && (beat_q == LEN - 12'd1) && !loop_en;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        en_d     = en_q;
        tick_d   = 1'b0;
        done_d   = done_q;
        presc_d  = presc_q;
        period_d = period_q;
        if (stop_pls) begin
            state_d = S_IDLE;
            beat_d  = 12'd0;
            en_d    = 1'b0;
            done_d  = 1'b0;
            presc_d = 32'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (play_pls) begin
                        state_d  = S_PLAY;
                        beat_d   = 12'd0;
                        presc_d  = 32'd0;
                        period_d = period_sel;
                        en_d     = 1'b1;
                        done_d   = 1'b0;
                    end
                end
                S_PLAY: begin
                    if (at_term) begin
                        presc_d  = 32'd0;
                        tick_d   = 1'b1;
                        period_d = period_sel;
                        if (beat_q == LEN - 12'd1) begin
                            if (loop_en) begin
                                beat_d = 12'd0;
                            end else begin
                                beat_d  = LEN;
                                state_d = S_DONE;
                                en_d    = 1'b0;
                                done_d  = 1'b1;
                            end
                        end else begin
                            beat_d = beat_q + 12'd1;
                        end
                    end else if (!play_pls) begin
                        presc_d = presc_q + 32'd1;
                    end
                    // A pause request on the final beat yields to the song ending.
                    if (play_pls && !finishing) begin
                        state_d = S_PAUSE;
                        en_d    = 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (play_pls) begin
                        state_d = S_PLAY;
                        en_d    = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            beat_q   <= 12'd0;
            en_q     <= 1'b0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
            presc_q  <= 32'd0;
            period_q <= BEAT_DIV;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            en_q     <= en_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
            presc_q  <= presc_d;
            period_q <= period_d;
        end
    end

    assign ibeatNum  = beat_q;
    assign en        = en_q;
    assign beat_tick = tick_q;
    assign done      = done_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// tb/tb_beat_sequencer.sv - directed and randomized checks of beat_sequencer against a behavioural transport model
module tb_beat_sequencer;

    localparam int DIV = 8;
    localparam int LEN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        play_pls = 1'b0;
    logic        stop_pls = 1'b0;
    logic        loop_en = 1'b0;
    logic [1:0]  tempo_sel = 2'd0;
    logic [11:0] ibeatNum;
    logic        en;
    logic        beat_tick;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: transport flags, current beat, clocks spent in this beat, beat length.
    bit m_playing, m_paused, m_finished, m_tick;
    int m_beat, m_elapsed, m_period;

    beat_sequencer #(.BEAT_DIV(32'd8), .LEN(12'd4)) dut (
        .clk(clk), .rst(rst), .play_pls(play_pls), .stop_pls(stop_pls),
        .loop_en(loop_en), .tempo_sel(tempo_sel), .ibeatNum(ibeatNum),
        .en(en), .beat_tick(beat_tick), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int per_of(input int t);
        int p;
        p = DIV >> t;
        return (p < 1) ? 1 : p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_playing = 0; m_paused = 0; m_finished = 0; m_tick = 0;
        m_beat = 0; m_elapsed = 0; m_period = DIV;
    endtask

    task automatic model_step(input bit p, input bit s);
        m_tick = 0;
        if (s) begin
            m_playing = 0; m_paused = 0; m_finished = 0;
            m_beat = 0; m_elapsed = 0;
        end else if (m_playing) begin
            if (m_elapsed + 1 == m_period) begin
                m_tick = 1;
                m_elapsed = 0;
                m_period = per_of(int'(tempo_sel));
                if (m_beat == LEN - 1) begin
                    if (loop_en) m_beat = 0;
                    else begin
                        m_beat = LEN; m_playing = 0; m_finished = 1;
                    end
                end else begin
                    m_beat++;
                end
                if (p && m_playing) begin
                    m_playing = 0; m_paused = 1;
                end
            end else if (p) begin
                m_playing = 0; m_paused = 1;
            end else begin
                m_elapsed++;
            end
        end else if (m_paused) begin
            if (p) begin
                m_paused = 0; m_playing = 1;
            end
        end else if (p) begin
            m_playing = 1; m_finished = 0;
            m_beat = 0; m_elapsed = 0;
            m_period = per_of(int'(tempo_sel));
        end
    endtask

    task automatic chk_all();
        chk("ibeatNum", 32'(ibeatNum), 32'(m_beat));
        chk("en", 32'(en), 32'(m_playing));
        chk("beat_tick", 32'(beat_tick), 32'(m_tick));
        chk("done", 32'(done), 32'(m_finished));
    endtask

    task automatic cyc(input bit p, input bit s);
        play_pls = p;
        stop_pls = s;
        @(posedge clk);
        model_step(p, s);
        #1;
        chk_all();
        play_pls = 1'b0;
        stop_pls = 1'b0;
    endtask

    int ticks, dones, n, n2;
    int seen[$];

    initial begin
        model_reset();
        #2 rst = 1'b1;
        #1;
        chk("reset_beat", 32'(ibeatNum), 32'd0);
        chk("reset_en", 32'(en), 32'd0);
        chk("reset_tick", 32'(beat_tick), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        @(negedge clk) rst = 1'b0;

        // 1: async reset mid-play at beat 2
        loop_en = 1'b1;
        cyc(1, 0);
        for (int i = 0; i < 19; i++) cyc(0, 0);
        chk("t1_at_beat2", 32'(ibeatNum), 32'd2);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("t1_async_beat", 32'(ibeatNum), 32'd0);
        chk("t1_async_en", 32'(en), 32'd0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 10; i++) cyc(0, 0);
        chk("t1_stays_idle", 32'(en), 32'd0);

        // 2: one-shot play, 4 beats of 8 clocks then DONE
        loop_en = 1'b0;
        tempo_sel = 2'd0;
        cyc(1, 0);
        chk("t2_en_next", 32'(en), 32'd1);
        ticks = 0;
        for (int i = 0; i < 31; i++) begin
            cyc(0, 0);
            if (beat_tick) ticks++;
        end
        chk("t2_not_done_yet", 32'(done), 32'd0);
        cyc(0, 0);
        if (beat_tick) ticks++;
        chk("t2_ticks", 32'(ticks), 32'd4);
        chk("t2_end_beat", 32'(ibeatNum), 32'd4);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_en_off", 32'(en), 32'd0);

        // 3: looping from DONE
        loop_en = 1'b1;
        cyc(1, 0);
        dones = 0;
        seen.delete();
        for (int i = 0; i < 48; i++) begin
            cyc(0, 0);
            if (done) dones++;
            if (beat_tick) seen.push_back(int'(ibeatNum));
        end
        chk("t3_done_never", 32'(dones), 32'd0);
        chk("t3_tick_count", 32'(seen.size()), 32'd6);
        if (seen.size() == 6) begin
            chk("t3_seq0", 32'(seen[0]), 32'd1);
            chk("t3_seq2", 32'(seen[2]), 32'd3);
            chk("t3_seq3_wrap", 32'(seen[3]), 32'd0);
            chk("t3_seq4", 32'(seen[4]), 32'd1);
        end

        // 4: pause at prescaler 5 of beat 1, resume
        cyc(0, 1);
        cyc(1, 0);
        for (int i = 0; i < 13; i++) cyc(0, 0);
        cyc(1, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0);
        chk("t4_paused_beat", 32'(ibeatNum), 32'd1);
        chk("t4_paused_en", 32'(en), 32'd0);
        cyc(1, 0);
        chk("t4_resume_en", 32'(en), 32'd1);
        cyc(0, 0);
        cyc(0, 0);
        chk("t4_not_yet", 32'(ibeatNum), 32'd1);
        cyc(0, 0);
        chk("t4_beat2_at_3", 32'(ibeatNum), 32'd2);
        chk("t4_tick_at_3", 32'(beat_tick), 32'd1);

        // 5: tempo change mid-beat
        cyc(0, 1);
        tempo_sel = 2'd0;
        cyc(1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0);
        tempo_sel = 2'd2;
        n = 0;
        do begin cyc(0, 0); n++; end while (!beat_tick && n < 20);
        chk("t5_current_beat_len", 32'(n), 32'd5);
        n2 = 0;
        do begin cyc(0, 0); n2++; end while (!beat_tick && n2 < 20);
        chk("t5_next_beat_len", 32'(n2), 32'd2);

        // 6: play+stop together, and stop on terminal count
        cyc(1, 1);
        chk("t6_beat", 32'(ibeatNum), 32'd0);
        chk("t6_no_tick", 32'(beat_tick), 32'd0);
        chk("t6_en", 32'(en), 32'd0);
        tempo_sel = 2'd0;
        cyc(1, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0);
        cyc(0, 1);
        chk("t6_term_stop_tick", 32'(beat_tick), 32'd0);
        chk("t6_term_stop_beat", 32'(ibeatNum), 32'd0);

        // randomized transport traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) loop_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) tempo_sel = 2'($urandom_range(0, 3));
            cyc(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
